// File: rtl/delay_line_pkg.sv
// Shared constants, stage shape and occupancy helper for the delay line.
package delay_line_pkg;

  localparam int DELAY_LINE_WIDTH_DEFAULT = 32'sd8;
  localparam int DELAY_LINE_DEPTH_DEFAULT = 32'sd2;
  localparam int DELAY_LINE_WIDTH_MIN     = 32'sd1;
  localparam int DELAY_LINE_WIDTH_MAX     = 32'sd64;
  localparam int DELAY_LINE_DEPTH_MIN     = 32'sd1;
  localparam int DELAY_LINE_DEPTH_MAX     = 32'sd32;

  // Stage shape at the default width; delay_line redeclares it at its own WIDTH.
  typedef struct packed {
    logic                                valid;
    logic [DELAY_LINE_WIDTH_DEFAULT-1:0] data;
  } delay_stage_t;

  function automatic int unsigned occupancy_next(
    input int unsigned cnt,
    input logic        flush,
    input logic        en,
    input logic        vin,
    input logic        vout
  );
    int unsigned nxt;
    if (flush) begin
      nxt = 32'd0;
    end else if (en) begin
      nxt = cnt + 32'(vin) - 32'(vout);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One valid+data pipeline register with enable, flush and bubble gating.
module delay_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Next-state: flush beats enable; a bubble always carries zero data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = {WIDTH{1'b0}};
    end else if (en_i) begin
      valid_d = valid_i;
      data_d  = valid_i ? data_i : {WIDTH{1'b0}};
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/delay_line.sv
// Enable-gated, flushable fixed-latency delay line of DEPTH stages.
// Optional occupancy counter and count_o port when DELAY_LINE_COUNT_EN is defined.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_WIDTH_DEFAULT,
  parameter int DEPTH = DELAY_LINE_DEPTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o
`ifdef DELAY_LINE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

  if ((WIDTH < DELAY_LINE_WIDTH_MIN) || (WIDTH > DELAY_LINE_WIDTH_MAX) ||
      (DEPTH < DELAY_LINE_DEPTH_MIN) || (DEPTH > DELAY_LINE_DEPTH_MAX)) begin : g_param_err
    $error("delay_line: WIDTH must be 1..64 and DEPTH must be 1..32");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t in_s    [DEPTH];
  stage_t stage_s [DEPTH];

  // Stage inputs: head takes the port, every later stage takes its predecessor.
  always_comb begin
    in_s[0].valid = valid_i;
    in_s[0].data  = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      in_s[k] = stage_s[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    delay_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_i),
      .flush_i (flush_i),
      .valid_i (in_s[k].valid),
      .data_i  (in_s[k].data),
      .valid_o (stage_s[k].valid),
      .data_o  (stage_s[k].data)
    );
  end

  assign valid_o = stage_s[DEPTH-1].valid;
  assign data_o  = stage_s[DEPTH-1].data;

`ifdef DELAY_LINE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_d, count_q;

  // Occupancy: entries in minus the entry leaving the final stage.
  always_comb begin
    count_d = CW'(occupancy_next(32'(count_q), flush_i, en_i, valid_i,
                                 stage_s[DEPTH-1].valid));
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 2: number of pipeline stages (latency), legal range 1..32; an illegal value SHALL fail elaboration.
REQ-003 Port clk_i  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_ni  input  1: reset, synchronous, active-low.
REQ-005 Port en_i  input  1: advance enable; 1 = shift all stages, 0 = hold.
REQ-006 Port flush_i  input  1: discard all in-flight entries.
REQ-007 Port valid_i  input  1: data_i carries a real sample this cycle.
REQ-008 Port data_i  input  WIDTH: sample in.
REQ-009 Port valid_o  output  1: valid bit of the final stage.
REQ-010 Port data_o  output  WIDTH: data of the final stage.
REQ-011 Port count_o  output  $clog2(DEPTH+1): number of valid stages (only with DELAY_LINE_COUNT_EN).

Function
REQ-012 Each stage k (0..DEPTH-1) SHALL hold a valid bit and a WIDTH-bit data register.
REQ-013 Cycle with en_i=1, flush_i=0: stage0 <= {valid_i, data_i}, stage k <= stage k-1 for k>=1.
REQ-014 Cycle with en_i=0, flush_i=0: all stages hold; valid_i/data_i ignored.
REQ-015 Bubble gating: a stage loaded with valid=0 SHALL load data 0, so data_o = 0 whenever valid_o = 0.
REQ-016 Latency: a sample accepted on an enabled edge SHALL appear on valid_o/data_o after exactly DEPTH enabled edges, regardless of intervening disabled cycles.
REQ-017 valid_o/data_o SHALL be driven directly from final-stage registers (no combinational path from any input).
REQ-018 flush_i=1: all valid bits and data SHALL clear to 0 on that edge; flush has priority over en_i, and a sample presented in the same cycle SHALL be discarded.
REQ-019 Ordering SHALL be strictly FIFO; no sample duplicated or dropped except by flush/reset.
REQ-020 DEPTH=1 SHALL behave as a single enable-gated register with identical rules.

Reset
REQ-021 rst_ni=0 at a rising edge SHALL clear every valid bit, every data register and the counter to 0; valid_o=0, data_o=0, count_o=0 on the following cycle.
REQ-022 Reset SHALL override flush_i and en_i; reset mid-stream SHALL discard all in-flight samples, identical to flush.
REQ-023 First enabled edge after reset release SHALL load stage0 normally.

Configuration
REQ-024 Macro DELAY_LINE_COUNT_EN defined: count_o port and occupancy counter present.
REQ-025 Counter update per edge: flush or reset -> 0; else if en_i -> count + valid_i - valid_o (final stage leaving); else hold; SHALL never exceed DEPTH nor underflow.
REQ-026 Macro undefined: count_o port and counter logic absent; all other behaviour unchanged.

Structure
REQ-027 Package delay_line_pkg SHALL hold default constants DELAY_LINE_WIDTH_DEFAULT=8, DELAY_LINE_DEPTH_DEFAULT=2 and the stage typedef (packed struct: valid bit + data), parameterised by width via the module.
REQ-028 One sub-module delay_stage (single valid+data register with en, flush, bubble gating) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=4)
REQ-029 After reset, en_i=1, valid_i=1, data_i=0x11,0x22,0x33,... each cycle -> valid_o first 1 on the 4th edge with data_o=0x11, then 0x22, 0x33 consecutively; count_o ramps 1,2,3,4 then holds 4.
REQ-030 Inject 0xA5 then en_i=0 for 5 cycles then en_i=1 -> outputs frozen during stall, 0xA5 emerges after 4 enabled edges total.
REQ-031 valid_i alternating 1/0 with data_i=0xFF constant -> data_o alternates 0xFF/0x00 in lockstep with valid_o; count_o never exceeds 2.
REQ-032 Pipeline full (count_o=4), flush_i=1 with en_i=1, valid_i=1, data_i=0x77 -> next cycle valid_o=0, data_o=0, count_o=0; 0x77 never appears.
REQ-033 Pipeline full, rst_ni=0 one cycle with en_i=1 -> all outputs 0 next cycle; next sample 0x5A emerges 4 enabled edges after release.
REQ-034 Rebuild with DEPTH=1 and without DELAY_LINE_COUNT_EN -> 0x3C in produces valid_o=1, data_o=0x3C one enabled edge later; elaborates without count_o.
